mem_arbiter: RTL and testbench

Arbiter and sequencer for a single unified memory port shared between the pipelined CPU's instruction fetch (F stage) and data access (M stage). It accepts one request at a time and issues a single-cycle command to a fixed-latency memory. It returns read data and a one-cycle ready pulse to the granted requester. Data accesses are favoured, but a streak limit prevents fetch starvation. The CPU stalls a stage while that stage's req is high and its ready is low.

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: sequences one fetch or data access at a time against a
// fixed-latency memory, favouring data accesses while bounding fetch starvation.
module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam int LAT_W    = $clog2(MEM_LAT + 1);
    localparam int STREAK_W = $clog2(STARVE_LIM + 1);
    localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(1'b1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic                owner_dm_r;
    logic                we_r;
    logic                cancel_r;
    logic [LAT_W-1:0]    lat_cnt_r;
    logic [STREAK_W-1:0] streak_r;
    logic                if_ready_r;
    logic                dm_ready_r;
    logic [31:0]         if_rdata_r;
    logic [31:0]         dm_rdata_r;
    logic                mem_en_r;
    logic                mem_we_r;
    logic [31:0]         mem_addr_r;
    logic [31:0]         mem_wdata_r;
    logic                busy_r;

    logic                grant_if_s;
    logic                grant_dm_s;
    logic                cancel_now_s;

    assign if_ready  = if_ready_r;
    assign if_rdata  = if_rdata_r;
    assign dm_ready  = dm_ready_r;
    assign dm_rdata  = dm_rdata_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;

    // Grant decision in IDLE and cancel status including a flush arriving this cycle
    always_comb begin
        grant_if_s   = 1'b0;
        grant_dm_s   = 1'b0;
        cancel_now_s = cancel_r | (if_flush & ~owner_dm_r);
        if (state_r == IDLE) begin
            // A flushed fetch is never granted, even when it has priority from starvation
            grant_if_s = if_req & ~if_flush & (~dm_req | (streak_r == STREAK_MAX));
            grant_dm_s = dm_req & ~grant_if_s;
        end else begin
            grant_if_s = 1'b0;
            grant_dm_s = 1'b0;
        end
    end

    // Arbitration FSM with registered memory command and requester responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_dm_r  <= 1'b0;
            we_r        <= 1'b0;
            cancel_r    <= 1'b0;
            lat_cnt_r   <= '0;
            streak_r    <= '0;
            if_ready_r  <= 1'b0;
            dm_ready_r  <= 1'b0;
            if_rdata_r  <= 32'h0000_0000;
            dm_rdata_r  <= 32'h0000_0000;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            busy_r      <= 1'b0;
        end else begin
            if_ready_r  <= 1'b0;
            dm_ready_r  <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            case (state_r)
                IDLE: begin
                    if (grant_if_s || grant_dm_s) begin
                        owner_dm_r  <= grant_dm_s;
                        we_r        <= grant_dm_s & dm_we;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= grant_dm_s & dm_we;
                        mem_addr_r  <= grant_dm_s ? dm_addr : if_addr;
                        mem_wdata_r <= grant_dm_s ? dm_wdata : 32'h0000_0000;
                        busy_r      <= 1'b1;
                        state_r     <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                    if (grant_if_s || !if_req) begin
                        streak_r <= '0;
                    end else if (grant_dm_s && (streak_r != STREAK_MAX)) begin
                        streak_r <= streak_r + 1'b1;
                    end else begin
                        streak_r <= streak_r;
                    end
                end
                ISSUE: begin
                    cancel_r  <= cancel_now_s;
                    lat_cnt_r <= LAT_LOAD;
                    state_r   <= WAIT;
                end
                WAIT: begin
                    cancel_r <= cancel_now_s;
                    if (lat_cnt_r == LAT_LAST) begin
                        lat_cnt_r <= '0;
                        state_r   <= DONE;
                        if (owner_dm_r) begin
                            dm_ready_r <= 1'b1;
                            if (!we_r) begin
                                dm_rdata_r <= mem_rdata;
                            end else begin
                                dm_rdata_r <= dm_rdata_r;
                            end
                        end else if (!cancel_now_s) begin
                            if_ready_r <= 1'b1;
                            if_rdata_r <= mem_rdata;
                        end else begin
                            if_rdata_r <= if_rdata_r;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 1'b1;
                    end
                end
                DONE: begin
                    cancel_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    cancel_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=2, STARVE_LIM=2) with a fixed-latency memory model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_flush = 1'b0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_wdata = 32'h0;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;
    int waited;
    int busy_cnt;
    int ready_cnt;
    logic [31:0] exp_addr [6] = '{32'h300, 32'h300, 32'h80, 32'h300, 32'h300, 32'h80};

    // Memory model: data valid exactly two cycles after the mem_en cycle, garbage otherwise
    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic [31:0] p1_a = 32'h0, p2_a = 32'h0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h40) return 32'hE3A0_1005;
        else return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk) begin
        p1_v <= mem_en;
        p1_a <= mem_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign mem_rdata = p2_v ? memval(p2_a) : 32'hBAD0_BAD0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(2), .STARVE_LIM(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_ctrl", {27'd0, busy, mem_en, mem_we, if_ready, dm_ready}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        next();

        // Single fetch
        if_req = 1'b1; if_addr = 32'h40;
        next();
        chk("f1_en", {31'd0, mem_en}, 32'h1);
        chk("f1_addr", mem_addr, 32'h40);
        chk("f1_we", {31'd0, mem_we}, 32'h0);
        chk("f1_busy", {31'd0, busy}, 32'h1);
        next();
        chk("f1_en_c2", {31'd0, mem_en}, 32'h0);
        chk("f1_addr_c2", mem_addr, 32'h0);
        next();
        chk("f1_rdy_c3", {31'd0, if_ready}, 32'h0);
        next();
        chk("f1_rdy_c4", {31'd0, if_ready}, 32'h1);
        chk("f1_rdata", if_rdata, 32'hE3A0_1005);
        if_req = 1'b0;
        next();
        chk("f1_rdy_c5", {31'd0, if_ready}, 32'h0);
        chk("f1_busy_c5", {31'd0, busy}, 32'h0);
        chk("f1_rdata_hold", if_rdata, 32'hE3A0_1005);

        // Simultaneous requests: data first, then fetch
        if_req = 1'b1; if_addr = 32'h44;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        next();
        chk("sim_d_en", {31'd0, mem_en}, 32'h1);
        chk("sim_d_addr", mem_addr, 32'h100);
        next(); next(); next();
        chk("sim_d_rdy", {31'd0, dm_ready}, 32'h1);
        chk("sim_d_rdata", dm_rdata, 32'h0100_FEFF);
        chk("sim_if_rdy_c4", {31'd0, if_ready}, 32'h0);
        dm_req = 1'b0;
        next();
        chk("sim_c5_en", {31'd0, mem_en}, 32'h0);
        next();
        chk("sim_f_en", {31'd0, mem_en}, 32'h1);
        chk("sim_f_addr", mem_addr, 32'h44);
        next(); next();
        chk("sim_f_rdy_c8", {31'd0, if_ready}, 32'h0);
        next();
        chk("sim_f_rdy_c9", {31'd0, if_ready}, 32'h1);
        chk("sim_f_rdata", if_rdata, 32'h0044_FFBB);
        if_req = 1'b0;
        next();

        // Store
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        next();
        chk("st_en_we", {30'd0, mem_en, mem_we}, 32'h3);
        chk("st_addr", mem_addr, 32'h200);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        next();
        chk("st_idle_cmd", {30'd0, mem_en, mem_we}, 32'h0);
        chk("st_idle_wdata", mem_wdata, 32'h0);
        next(); next();
        chk("st_rdy", {31'd0, dm_ready}, 32'h1);
        chk("st_rdata_keep", dm_rdata, 32'h0100_FEFF);
        dm_req = 1'b0; dm_we = 1'b0;
        next();
        chk("st_rdy_c5", {31'd0, dm_ready}, 32'h0);

        // Starvation limit: D, D, F, D, D, F
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        for (int g = 0; g < 6; g++) begin
            waited = 0;
            while (mem_en !== 1'b1 && waited < 12) begin
                next();
                waited++;
            end
            chk("starve_grant_seen", {31'd0, mem_en}, 32'h1);
            chk("starve_order", mem_addr, exp_addr[g]);
            chk("starve_spacing", waited, (g == 0) ? 32'd1 : 32'd4);
            next();
        end
        dm_req = 1'b0;
        next(); next();
        chk("starve_f_rdy", {31'd0, if_ready}, 32'h1);
        chk("starve_f_rdata", if_rdata, 32'h0080_FF7F);
        if_req = 1'b0;
        next();

        // Flush of a fetch in WAIT
        if_req = 1'b1; if_addr = 32'h48;
        busy_cnt = 0; ready_cnt = 0;
        next();
        chk("fl_en", {31'd0, mem_en}, 32'h1);
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin
                if_flush = 1'b1; if_req = 1'b0;
            end else begin
                if_flush = 1'b0;
            end
            busy_cnt += int'(busy);
            ready_cnt += int'(if_ready);
            if (c < 5) next();
        end
        chk("fl_busy_len", busy_cnt, 32'd4);
        chk("fl_no_ready", ready_cnt, 32'd0);
        chk("fl_rdata_keep", if_rdata, 32'h0080_FF7F);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
        next();
        chk("fl_d_en", {31'd0, mem_en}, 32'h1);
        chk("fl_d_addr", mem_addr, 32'h104);
        next(); next(); next();
        chk("fl_d_rdy", {31'd0, dm_ready}, 32'h1);
        chk("fl_d_rdata", dm_rdata, 32'h0104_FEFB);
        dm_req = 1'b0;
        next();

        // Reset asserted mid-WAIT
        dm_req = 1'b1; dm_addr = 32'h108;
        next();
        chk("rw_en", {31'd0, mem_en}, 32'h1);
        next();
        #3 reset = 1'b1; dm_req = 1'b0;
        #1;
        chk("rw_async_ctrl", {27'd0, busy, mem_en, mem_we, if_ready, dm_ready}, 32'h0);
        chk("rw_async_rdata", dm_rdata, 32'h0);
        chk("rw_async_if_rdata", if_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ready_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            next();
            ready_cnt += int'(dm_ready) + int'(if_ready) + int'(busy);
        end
        chk("rw_quiet", ready_cnt, 32'd0);
        chk("rw_rdata_ignored", dm_rdata, 32'h0);
        dm_req = 1'b1; dm_addr = 32'h10C;
        next();
        chk("rw_new_en", {31'd0, mem_en}, 32'h1);
        next(); next(); next();
        chk("rw_new_rdy", {31'd0, dm_ready}, 32'h1);
        chk("rw_new_rdata", dm_rdata, 32'h010C_FEF3);
        dm_req = 1'b0;
        next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
